// File: rtl/mux_n_hs.sv
// Purpose: N-input registered mux with valid/ready handshakes; explicit-select or round-robin choice.
// Latency: 1 cycle from input transfer to out_valid/out_data; 1 word/cycle with out_ready held high.
// Backpressure: a single output register loads when empty or being popped; all in_ready drop on stall.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data/in_valid    NUM_IN packed inputs (input i at [i*WIDTH +: WIDTH]) and their valids
//   in_ready            one-hot grant (or zero) back to the inputs
//   sel, mode           explicit index (mode=0) or round-robin arbitration (mode=1)
//   out_data/out_valid  registered selected word, handshaked by out_ready
//   out_src             index of the input that supplied out_data
module mux_n_hs #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
);

  // Inputs are padded out to the full index space so any SEL_W-bit index
  // is in range; padded slots are never valid and never granted.
  localparam int EXT_N = 1 << SEL_W;

  logic             r_out_vld;
  logic [WIDTH-1:0] r_out_dat;
  logic [SEL_W-1:0] r_out_src;
  logic [SEL_W-1:0] r_last;

  logic [WIDTH-1:0] w_in_arr [EXT_N];
  logic [EXT_N-1:0] w_vld_ext;
  logic             w_can_load;
  logic             w_rr_found;
  logic [SEL_W-1:0] w_rr_idx;
  logic [SEL_W-1:0] w_rr_try;
  logic             w_cand_ok;
  logic [SEL_W-1:0] w_cand;
  logic             w_xfer;
  logic [WIDTH-1:0] w_cand_dat;

  for (genvar g = 0; g < EXT_N; g++) begin : g_unpack
    if (g < NUM_IN) begin : g_real
      assign w_in_arr[g] = in_data[g*WIDTH +: WIDTH];
    end else begin : g_pad
      assign w_in_arr[g] = '0;
    end
  end

  assign w_vld_ext  = EXT_N'(in_valid);
  assign w_can_load = !r_out_vld || out_ready;

  // Round-robin search: first valid input after the last granted one,
  // wrapping modulo NUM_IN (not modulo 2**SEL_W).
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_rr_try   = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      w_rr_try = SEL_W'((int'(r_last) + k) % NUM_IN);
      if (!w_rr_found && w_vld_ext[w_rr_try]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_rr_try;
      end
    end
  end

  always_comb begin
    w_cand    = sel;
    w_cand_ok = 1'b0;
    if (mode) begin
      w_cand    = w_rr_idx;
      w_cand_ok = w_rr_found;
    end else begin
      // An out-of-range select yields no candidate at all.
      w_cand_ok = (int'(sel) < NUM_IN) && w_vld_ext[sel];
    end
  end

  // Gating with rst_n keeps every ready low while reset is held.
  assign w_xfer     = rst_n && w_cand_ok && w_can_load;
  assign w_cand_dat = w_in_arr[w_cand];

  always_comb begin
    in_ready = '0;
    if (w_xfer) begin
      in_ready = NUM_IN'(1) << w_cand;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
      r_out_src <= '0;
      r_last    <= SEL_W'(NUM_IN - 1);
    end else if (w_xfer) begin
      // A push in the same cycle as a pop simply overwrites: no bubble.
      r_out_vld <= 1'b1;
      r_out_dat <= w_cand_dat;
      r_out_src <= w_cand;
      r_last    <= w_cand;
    end else if (out_ready) begin
      r_out_vld <= 1'b0;
    end
  end

  assign out_valid = r_out_vld;
  assign out_data  = r_out_dat;
  assign out_src   = r_out_src;

endmodule

// File: doc/mux_n_hs.md
Name: mux_n_hs

Overview:
- Parametrised N-input, W-bit registered multiplexer with valid/ready handshakes on every input and on the output.
- Successor to the fixed 4-input combinational datapath mux.
- Two modes:
  - explicit select: a control-unit-driven sel chooses the input.
  - round-robin: the block arbitrates fairly among valid inputs.
- Sits between multicycle-datapath producers (register file, ALU result, memory data, PC sources) and a single consumer register. It allows back-pressure instead of relying only on fixed control timing.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 4, number of inputs; legal range 2..16.
- SEL_W, 2, select/index width; must equal clog2(NUM_IN).

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_data  input  NUM_IN*WIDTH  concatenated inputs; input i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-input valid.
- in_ready  output  NUM_IN  per-input ready; one-hot or zero.
- sel  input  SEL_W  input index used in explicit mode.
- mode  input  1  0 = explicit select, 1 = round-robin.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_src  output  SEL_W  index of the input that supplied out_data.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - out_valid=0, out_data=0, out_src=0.
  - RR pointer last=NUM_IN-1, so the first round-robin search starts at input 0.
  - in_ready=0 while rst_n=0.
- Output stage is a single register.
  - can_load = !out_valid || out_ready.
  - Full throughput of 1 word/cycle when out_ready is held at 1.
  - Latency: an input transfer in cycle t gives out_valid=1 with that data in cycle t+1.
- Candidate selection (combinational, same cycle):
  - mode=0: cand=sel. If sel>=NUM_IN, there is no candidate.
  - mode=1: cand = first i with in_valid[i]=1, searching last+1, last+2, … modulo NUM_IN; wraps past NUM_IN-1 to 0.
- Grant: grant[cand]=1 iff a candidate exists, in_valid[cand]=1 and can_load=1.
  - in_ready = grant.
  - Transfer on input i when in_valid[i] && in_ready[i].
- in_ready may depend on in_valid. Producers must not make in_valid depend on in_ready.
- In explicit mode, in_ready[sel] is 0 whenever in_valid[sel]=0; no other input is ever readied.
- On transfer from input i: out_data <= in_data[i], out_src <= i, out_valid <= 1, last <= i. last updates in both modes.
- On out_ready && out_valid with no new transfer: out_valid <= 0; out_data and out_src hold.
- Simultaneous output pop and input push: the new word replaces the old one and out_valid stays 1. There is no bubble.
- Stall (out_valid=1, out_ready=0): out_data, out_src and out_valid hold; all in_ready=0.
- Changes to mode or sel take effect in the same cycle's candidate selection. A word already in the output register is unaffected.
- Reset asserted mid-stream: the held word is discarded immediately (asynchronously). No transfer completes in a cycle where rst_n=0.
- Round-robin fairness: an input continuously valid is granted within NUM_IN accepted transfers.

Test Plan:
- Reset, then mode=0, sel=2, in_valid=4'b0100, in_data[2]=32'hDEADBEEF, out_ready=1 -> in_ready=4'b0100 in the same cycle; next cycle out_valid=1, out_data=DEADBEEF, out_src=2.
- Stall: word held, out_ready=0 for 3 cycles, in_valid=4'b1111 -> in_ready=0, out_data and out_src unchanged; on out_ready=1 the pop and a new push occur in the same cycle and out_valid stays 1.
- mode=1, in_valid=4'b1111, out_ready=1 held 8 cycles after reset -> out_src sequence 0,1,2,3,0,1,2,3.
- mode=1, in_valid=4'b1001 with last=0 -> grants go 3 then 0 then 3, exercising the wrap-around.
- mode=0, sel=2, in_valid=4'b1011 -> in_ready=0 and out_valid falls after any pending pop. A NUM_IN=3 build with sel=3 -> no grant.
- rst_n pulled low mid-cycle while out_valid=1 -> out_valid=0 immediately without waiting for a clock edge; after release the first RR grant goes to input 0.
